mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main-memory read port between I- and D-cache block fills.
// D-cache misses win ties; one 8-word fill is in flight at a time.
module mem_arbiter #(
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_addr,
  input  logic        d_miss,
  input  logic [15:0] d_addr,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  input  logic [15:0] mem_data,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);
  localparam logic [2:0] LAST = 3'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t      state_q, state_d;
  logic        sel_q, sel_d, mem_en_q, mem_en_d;
  logic        i_done_q, i_done_d, d_done_q, d_done_d, busy_q;
  logic [15:0] base_q, base_d, mem_addr_q, mem_addr_d;
  logic [2:0]  iss_q, iss_d, rcv_q, rcv_d;
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    base_d     = base_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        iss_d = 3'd0;
        rcv_d = 3'd0;
        if (d_miss || i_miss) begin
          state_d    = FILL;
          sel_d      = d_miss;
          base_d     = (d_miss ? d_addr : i_addr) & 16'hFFF0;
          mem_en_d   = 1'b1;
          mem_addr_d = base_d;
        end
      end
      FILL: begin
        fill_we = mem_valid;
        // Issue runs ahead of receive; the two counters never interact.
        if (mem_en_q && iss_q != LAST) begin
          mem_en_d   = 1'b1;
          iss_d      = iss_q + 3'd1;
          mem_addr_d = base_q | {12'h000, iss_d, 1'b0};
        end
        if (mem_valid) begin
          rcv_d = rcv_q + 3'd1;
          if (rcv_q == LAST) begin
            state_d  = DONE;
            i_done_d = !sel_q;
            d_done_d = sel_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      base_q     <= 16'h0000;
      iss_q      <= 3'd0;
      rcv_q      <= 3'd0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= 16'h0000;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      base_q     <= base_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      busy_q     <= state_d != IDLE;
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign fill_sel  = sel_q;
  assign fill_word = rcv_q;
  assign fill_data = mem_data;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a fixed-latency pipelined memory model.
module tb_mem_arbiter;
  localparam int L = 4;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b1, force_v = 1'b0;
  logic        i_miss = 1'b0, d_miss = 1'b0;
  logic [15:0] i_addr = 16'h0, d_addr = 16'h0, force_d = 16'h0;
  logic        mem_en, mem_valid, fill_we, fill_sel, i_done, d_done, busy;
  logic [15:0] mem_addr, mem_data, fill_data;
  logic [2:0]  fill_word;
  logic [L:0]  v;
  logic [15:0] a [0:L];
  int n_assert = 0, n_fail = 0;

  mem_arbiter #(.WORDS(8)) dut (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: a request seen at an edge returns L+1 cycles later; data = addr ^ A5C3.
  always @(posedge clk) begin
    if (flush) v <= '0;
    else begin
      v    <= {v[L-1:0], mem_en};
      a[0] <= mem_addr;
      for (int i = 1; i <= L; i++) a[i] <= a[i-1];
    end
  end
  assign mem_valid = v[L] | force_v;
  assign mem_data  = force_v ? force_d : a[L] ^ 16'hA5C3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_mem_en"}, mem_en, 1'b0);
    chk({tag, "_fill_we"}, fill_we, 1'b0);
    chk({tag, "_i_done"}, i_done, 1'b0);
    chk({tag, "_d_done"}, d_done, 1'b0);
  endtask

  // Called one cycle before the grant edge; c = 0 is the first FILL cycle.
  task automatic run_fill(input logic sel, input logic [15:0] base, input int drop);
    for (int c = 0; c < 14; c++) begin
      step();
      chk("mem_en", mem_en, 16'(c < 8));
      if (c < 8) chk("mem_addr", mem_addr, base + 16'(2 * c));
      chk("fill_we", fill_we, 16'(c >= 5 && c < 13));
      if (c >= 5 && c < 13) begin
        chk("fill_word", fill_word, 16'(c - 5));
        chk("fill_data", fill_data, (base + 16'(2 * (c - 5))) ^ 16'hA5C3);
        chk("fill_sel", fill_sel, sel);
      end
      chk("busy", busy, 1'b1);
      chk("i_done", i_done, 16'(c == 13 && !sel));
      chk("d_done", d_done, 16'(c == 13 && sel));
      if (c == drop || c == 13) begin
        if (sel) d_miss = 1'b0;
        else i_miss = 1'b0;
      end
    end
    step();
    chk_idle("post_done");
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_fill_sel", fill_sel, 1'b0);
    step();
    step();
    rst    = 1'b0;
    flush  = 1'b0;
    i_addr = 16'h1236;
    i_miss = 1'b1;
    run_fill(1'b0, 16'h1230, 13);

    i_addr = 16'h5678;
    d_addr = 16'h8004;
    i_miss = 1'b1;
    d_miss = 1'b1;
    run_fill(1'b1, 16'h8000, 13);
    run_fill(1'b0, 16'h5670, 13);

    d_addr = 16'h4004;
    d_miss = 1'b1;
    run_fill(1'b1, 16'h4000, 1);

    force_v = 1'b1;
    force_d = 16'hBEEF;
    #1;
    chk("spurious_fill_we", fill_we, 1'b0);
    step();
    chk_idle("spurious");
    force_v = 1'b0;
    d_addr  = 16'hFFFA;
    d_miss  = 1'b1;
    run_fill(1'b1, 16'hFFF0, 13);

    d_addr = 16'h2000;
    d_miss = 1'b1;
    for (int c = 0; c < 11; c++) step();
    chk("pre_rst_word", fill_word, 16'd5);
    rst    = 1'b1;
    d_miss = 1'b0;
    flush  = 1'b1;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_mem_addr", mem_addr, 16'h0000);
    chk("rst_mid_fill_word", fill_word, 16'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_hold_d_done", d_done, 1'b0);
    end
    rst    = 1'b0;
    flush  = 1'b0;
    d_addr = 16'h3008;
    d_miss = 1'b1;
    run_fill(1'b1, 16'h3000, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
